// File: rtl/i2s_pkg.sv
// ============================================================================
// i2s_pkg : shared sample/frame types and default timing for the I2S transmitter
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

  localparam int I2S_SLOT_W   = 32;
  localparam int I2S_BCLK_DIV = 4;

  typedef logic signed [23:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } frame_t;

endpackage

`default_nettype wire

// File: rtl/i2s_clk_gen.sv
// ============================================================================
// i2s_clk_gen : divides clk down to BCLK and flags each BCLK falling edge
// Revision    : 1.0
// ============================================================================
`default_nettype none

module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic bclk,
  output logic fall_tick
);

  localparam int c_div_w = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);

  logic [c_div_w-1:0] r_div_cnt;
  logic               r_bclk;
  logic               w_toggle;

  assign w_toggle = (r_div_cnt == c_div_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_toggle) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Strobe coincides with the edge that drives bclk low, so data changes with the fall
  assign fall_tick = w_toggle & r_bclk;
  assign bclk      = r_bclk;

endmodule

`default_nettype wire

// File: rtl/i2s_tx.sv
// ============================================================================
// i2s_tx : one-frame buffered I2S (Philips) master transmitter, MSB first
// Optional: define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt port
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_tx
  import i2s_pkg::*;
#(
  parameter int N        = $bits(sample_t),
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] left_in,
  input  logic [N-1:0] right_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         bclk,
  output logic         lrclk,
  output logic         sdata,
  output logic         underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]  underrun_cnt
`endif
);

  localparam int c_cnt_w = $clog2(2 * SLOT_W);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(2 * SLOT_W - 1);
  localparam logic [c_cnt_w-1:0] c_slot     = c_cnt_w'(SLOT_W);
  localparam logic [c_cnt_w-1:0] c_n        = c_cnt_w'(N);

  logic               w_fall_tick;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [c_cnt_w-1:0] w_bit_nxt;
  logic [c_cnt_w-1:0] w_slot_bit;
  logic               w_frame_start;
  logic               w_accept;
  logic               w_data_bit;
  logic               r_buf_full;
  logic [2*N-1:0]     r_buf;
  logic [2*N-1:0]     r_shift;
  logic               r_lrclk;
  logic               r_sdata;
  logic               r_underrun;

  i2s_clk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .bclk      (bclk),
    .fall_tick (w_fall_tick)
  );

  always_comb begin
    w_bit_nxt     = (r_bit_cnt == c_cnt_last) ? '0 : r_bit_cnt + 1'b1;
    w_slot_bit    = (w_bit_nxt >= c_slot) ? w_bit_nxt - c_slot : w_bit_nxt;
    w_data_bit    = (w_slot_bit != '0) && (w_slot_bit <= c_n);
    w_frame_start = w_fall_tick && (w_bit_nxt == '0);
    w_accept      = in_valid && !r_buf_full;
  end

  // Frame start sees the registered buffer state, so a same-cycle accept waits a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
    end else if (w_frame_start && r_buf_full) begin
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf      <= {left_in, right_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt  <= c_cnt_last;
      r_lrclk    <= 1'b1;
      r_sdata    <= 1'b0;
      r_shift    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frame_start && !r_buf_full;
      if (w_fall_tick) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= (w_bit_nxt >= c_slot);
        if (w_frame_start) begin
          r_shift <= r_buf_full ? r_buf : '0;
          r_sdata <= 1'b0;
        end else if (w_data_bit) begin
          // Left word leaves first; after it the right word sits at the top
          r_sdata <= r_shift[2*N-1];
          r_shift <= {r_shift[2*N-2:0], 1'b0};
        end else begin
          r_sdata <= 1'b0;
        end
      end
    end
  end

  assign in_ready = ~r_buf_full;
  assign lrclk    = r_lrclk;
  assign sdata    = r_sdata;
  assign underrun = r_underrun;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun_cnt <= '0;
    end else if (w_frame_start && !r_buf_full && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// ============================================================================
// tb_i2s_tx : directed self-checking bench for i2s_tx (default parameters)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_i2s_tx;

  logic        clk;
  logic        reset_n;
  logic [23:0] left_in;
  logic [23:0] right_in;
  logic        in_valid;
  logic        in_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ur_hi    = 0;

  i2s_tx u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .left_in  (left_in),
    .right_in (right_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts clk cycles with underrun high; each underrun frame should add exactly one
  always @(negedge clk) if (underrun === 1'b1) ur_hi++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"},     bclk,     1'b0);
    check({tag, "_lrclk"},    lrclk,    1'b1);
    check({tag, "_sdata"},    sdata,    1'b0);
    check({tag, "_underrun"}, underrun, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  // Cycle-exact checks for the first 8 cycles after reset release
  task automatic startup(input logic exp_rdy1, input logic exp_ur);
    for (int c = 1; c <= 8; c++) begin
      step();
      case (c)
        1: begin
          check("su_ready_c1", in_ready, exp_rdy1);
          in_valid = 1'b0;
        end
        3: check("su_bclk_c3", bclk, 1'b0);
        4: check("su_bclk_c4", bclk, 1'b1);
        7: begin
          check("su_bclk_c7",  bclk,  1'b1);
          check("su_lrclk_c7", lrclk, 1'b1);
        end
        8: begin
          check("su_bclk_c8",     bclk,     1'b0);
          check("su_lrclk_c8",    lrclk,    1'b0);
          check("su_ready_c8",    in_ready, 1'b1);
          check("su_underrun_c8", underrun, exp_ur);
        end
        default: ;
      endcase
    end
  endtask

  task automatic wait_frame_start();
    int   n     = 0;
    logic prev;
    logic found = 1'b0;
    while (n < 1100 && !found) begin
      prev = lrclk;
      step();
      n++;
      found = prev && !lrclk;
    end
    check("frame_start_seen", found, 1'b1);
  endtask

  // Samples lrclk/sdata on 64 consecutive bclk rises, as the DAC would
  task automatic capture(output logic [63:0] bits, output logic [63:0] lr);
    int   j     = 0;
    int   guard = 0;
    int   last  = 0;
    int   bad   = 0;
    logic prev;
    bits = '0;
    lr   = '0;
    prev = bclk;
    while (j < 64 && guard < 1000) begin
      step();
      guard++;
      if (bclk && !prev) begin
        bits[63-j] = sdata;
        lr[63-j]   = lrclk;
        if (j > 0 && (cyc - last) != 8) bad++;
        last = cyc;
        j++;
      end
      prev = bclk;
    end
    check("capture_rises", j, 64);
    check("bclk_period", bad, 0);
  endtask

  task automatic check_frame(input string tag, input logic [23:0] l, input logic [23:0] r);
    logic [63:0] bits;
    logic [63:0] lr;
    logic [63:0] mask;
    capture(bits, lr);
    mask        = '0;
    mask[62:39] = '1;
    mask[30:7]  = '1;
    check({tag, "_left"},  bits[62:39], l);
    check({tag, "_right"}, bits[30:7],  r);
    check({tag, "_pad"},   bits & ~mask, 64'h0);
    check({tag, "_lrclk"}, lr, 64'h00000000_FFFFFFFF);
  endtask

  initial begin
    int   n;
    int   hi;
    logic prev;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    left_in  = '0;
    right_in = '0;
    #23;
    check_reset_outputs("rst0");

    // Pair presented before release is accepted on the first clock
    left_in  = 24'h800001;
    right_in = 24'h7FFFFE;
    in_valid = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    cyc     = 0;
    startup(1'b0, 1'b0);
    check_frame("f0", 24'h800001, 24'h7FFFFE);

    wait_frame_start();
    check("f1_underrun", underrun, 1'b1);
    check_frame("f1", 24'h0, 24'h0);

    wait_frame_start();
    check("f2_underrun", underrun, 1'b1);
    repeat (100) step();
    left_in  = 24'h123456;
    right_in = 24'hABCDEF;
    in_valid = 1'b1;
    step();
    check("bp_ready_low", in_ready, 1'b0);
    left_in  = 24'hFFFFFF;
    right_in = 24'h000000;
    n  = 0;
    hi = 0;
    while (n < 1100) begin
      prev = lrclk;
      step();
      n++;
      if (prev && !lrclk) break;
      if (in_ready) hi++;
    end
    in_valid = 1'b0;
    check("bp_frame_seen", (n < 1100), 1'b1);
    check("bp_ready_held", hi, 0);
    check("bp_ready_rise", in_ready, 1'b1);
    check("f3_underrun", underrun, 1'b0);
    check_frame("f3", 24'h123456, 24'hABCDEF);

    // Accept lands exactly on the next frame-start edge
    repeat (3) step();
    left_in  = 24'h5A5A5A;
    right_in = 24'hA5A5A5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("sim_frame_start", lrclk, 1'b0);
    check("sim_underrun", underrun, 1'b1);
    check("sim_held", in_ready, 1'b0);
    check_frame("f4", 24'h0, 24'h0);
    wait_frame_start();
    check("f5_underrun", underrun, 1'b0);
    check_frame("f5", 24'h5A5A5A, 24'hA5A5A5);
    check("ur_pulses_3", ur_hi, 3);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("ur_cnt_3", underrun_cnt, 16'd3);
`endif

    // Reset mid right slot with a second pair waiting in the buffer
    left_in  = 24'h400000;
    right_in = 24'hFFFFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_frame_start();
    check("f6_underrun", underrun, 1'b0);
    repeat (10) step();
    left_in  = 24'h111111;
    right_in = 24'h222222;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("rst_buf_full", in_ready, 1'b0);
    repeat (289) step();
    check("pre_rst_lrclk", lrclk, 1'b1);
    check("pre_rst_sdata", sdata, 1'b1);
    check("pre_rst_bclk",  bclk,  1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst1");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc     = 0;
    startup(1'b1, 1'b1);
    check_frame("f_post", 24'h0, 24'h0);
    check("ur_pulses_4", ur_hi, 4);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("ur_cnt_post", underrun_cnt, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
